// File: rtl/matrix_result_drain_pkg.sv
// Shared constants and state encoding for the systolic-array result drain.
package matrix_result_drain_pkg;
    localparam int ACC_W_DEF = 16;
    localparam int OUT_W_DEF = 8;
    localparam int N_ELEM    = 9;
    localparam int IDX_W     = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/matrix_result_drain_if.sv
// Array-side capture inputs plus the valid/ready result stream of the drain.
interface matrix_result_drain_if
    import matrix_result_drain_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic                   done;
    logic [9*ACC_W-1:0]     c_flat;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   out_sat;
    logic                   busy;
    logic                   overrun;
    logic                   clr_overrun;

    modport master (
        output done, c_flat, out_ready, clr_overrun,
        input  out_valid, out_data, out_idx, out_last, out_sat, busy, overrun
    );

    modport slave (
        input  done, c_flat, out_ready, clr_overrun,
        output out_valid, out_data, out_idx, out_last, out_sat, busy, overrun
    );
endinterface

// File: rtl/matrix_result_drain_sat_trunc.sv
// Combinational signed saturation of an ACC_W result down to OUT_W, with clip flag.
module matrix_result_drain_sat_trunc #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] i_val,
    output logic [OUT_W-1:0] o_val,
    output logic             o_sat
);
    generate
        if (OUT_W == ACC_W) begin : g_pass
            assign o_val = i_val;
            assign o_sat = 1'b0;
        end else begin : g_clip
            localparam logic signed [ACC_W-1:0] MAX_V =
                {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] MIN_V =
                {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

            always_comb begin
                o_val = i_val[OUT_W-1:0];
                o_sat = 1'b0;
                if ($signed(i_val) > MAX_V) begin
                    o_val = MAX_V[OUT_W-1:0];
                    o_sat = 1'b1;
                end else if ($signed(i_val) < MIN_V) begin
                    o_val = MIN_V[OUT_W-1:0];
                    o_sat = 1'b1;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/matrix_result_drain.sv
// Snapshots the nine MAC results on a done edge, saturates them, and streams
// them out row-major so the array can restart as soon as the capture is taken.
module matrix_result_drain
    import matrix_result_drain_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_result_drain_if.slave  bus
);
    state_t             r_state;
    state_t             w_nextState;
    logic [IDX_W-1:0]   r_idx;
    logic               r_doneQ;
    logic               r_armed;
    logic               r_overrun;
    logic [OUT_W-1:0]   r_data [N_ELEM];
    logic [N_ELEM-1:0]  r_sat;

    logic [OUT_W-1:0]   w_satVal [N_ELEM];
    logic [N_ELEM-1:0]  w_satFlag;
    logic               w_doneRise;
    logic               w_accept;
    logic               w_lastBeat;
    logic               w_capture;

    for (genvar k = 0; k < N_ELEM; k++) begin : g_sat
        matrix_result_drain_sat_trunc #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
            .i_val (bus.c_flat[k*ACC_W +: ACC_W]),
            .o_val (w_satVal[k]),
            .o_sat (w_satFlag[k])
        );
    end

    // A done level already high when reset releases is not a fresh edge;
    // r_armed waits until done has been seen low at least once.
    assign w_doneRise = bus.done & ~r_doneQ & r_armed;
    assign w_accept   = (r_state == STREAM) & bus.out_ready;
    assign w_lastBeat = (r_idx == IDX_W'(N_ELEM - 1));

    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_doneRise) begin
                    w_capture   = 1'b1;
                    w_nextState = STREAM;
                end
            end
            STREAM: begin
                if (w_accept && w_lastBeat) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx     <= '0;
            r_doneQ   <= 1'b0;
            r_armed   <= 1'b0;
            r_overrun <= 1'b0;
            r_sat     <= '0;
            for (int k = 0; k < N_ELEM; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_doneQ <= bus.done;
            r_armed <= r_armed | ~bus.done;
            if (w_capture) begin
                r_idx <= '0;
                r_sat <= w_satFlag;
                for (int k = 0; k < N_ELEM; k++) begin
                    r_data[k] <= w_satVal[k];
                end
            end else if (w_accept) begin
                r_idx <= w_lastBeat ? '0 : r_idx + 1'b1;
            end
            // Set outranks clear when both land in the same cycle.
            if (w_doneRise && (r_state == STREAM)) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (r_state == STREAM);
    assign bus.busy      = (r_state == STREAM);
    assign bus.out_idx   = r_idx;
    assign bus.out_data  = r_data[r_idx];
    assign bus.out_sat   = r_sat[r_idx];
    assign bus.out_last  = w_lastBeat & (r_state == STREAM);
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed, table-driven bench for the matrix result drain.
module tb_matrix_result_drain;
    localparam int ACC_W = 16;
    localparam int OUT_W = 8;

    typedef struct {
        int acc;
        int expOut;
        bit expSat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matrix_result_drain_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    matrix_result_drain #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    vec_t tab [9];
    int vals [9];
    int expData [9];
    bit expSat [9];
    int lastCyc;
    int seen;
    logic [9*ACC_W-1:0] altFlat;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [9*ACC_W-1:0] packFlat(input int v [9]);
        logic [9*ACC_W-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            r[k*ACC_W +: ACC_W] = ACC_W'(v[k]);
        end
        return r;
    endfunction

    // Raises done at the current negedge, then drains one full stream and
    // compares each accepted word against expData/expSat in order.
    task automatic applyStimulus(input int readyMode, input bit holdDone, input int injectBeat,
                                 input logic [9*ACC_W-1:0] injFlat, output int lastAccept);
        int cycle = 0;
        int nAcc = 0;
        bit stall = 1'b0;
        int pData = 0;
        int pIdx = 0;
        lastAccept = -1;
        bus.done = 1'b1;
        while (nAcc < 9 && cycle < 60) begin
            @(negedge clk);
            cycle++;
            if (!holdDone) bus.done = 1'b0;
            if (injectBeat >= 0 && cycle == injectBeat + 1) begin
                bus.done   = 1'b1;
                bus.c_flat = injFlat;
            end
            bus.out_ready = (readyMode == 0) ? 1'b1 : (cycle % 2 == 0);
            if (cycle == 1) checkOutput("first beat latency valid", int'(bus.out_valid), 1);
            if (bus.out_valid) begin
                checkOutput("busy while streaming", int'(bus.busy), 1);
                if (stall) begin
                    checkOutput("stalled data stable", int'($signed(bus.out_data)), pData);
                    checkOutput("stalled idx stable", int'(bus.out_idx), pIdx);
                end
                if (bus.out_ready) begin
                    checkOutput("beat idx", int'(bus.out_idx), nAcc);
                    checkOutput("beat data", int'($signed(bus.out_data)), expData[nAcc]);
                    checkOutput("beat sat", int'(bus.out_sat), int'(expSat[nAcc]));
                    checkOutput("beat last", int'(bus.out_last), (nAcc == 8) ? 1 : 0);
                    nAcc++;
                    lastAccept = cycle;
                end
                stall = !bus.out_ready;
                pData = int'($signed(bus.out_data));
                pIdx  = int'(bus.out_idx);
            end else begin
                stall = 1'b0;
            end
        end
        checkOutput("accepted word count", nAcc, 9);
        @(negedge clk);
        checkOutput("busy after stream", int'(bus.busy), 0);
        checkOutput("valid after stream", int'(bus.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        bus.done        = 1'b0;
        bus.c_flat      = '0;
        bus.out_ready   = 1'b0;
        bus.clr_overrun = 1'b0;
        altFlat         = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", int'(bus.out_valid), 0);
        checkOutput("reset out_data", int'(bus.out_data), 0);
        checkOutput("reset out_idx", int'(bus.out_idx), 0);
        checkOutput("reset out_last", int'(bus.out_last), 0);
        checkOutput("reset out_sat", int'(bus.out_sat), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset overrun", int'(bus.overrun), 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] full-rate stream of 1..9");
        for (int k = 0; k < 9; k++) begin
            vals[k] = k + 1;
            expData[k] = k + 1;
            expSat[k] = 1'b0;
        end
        bus.c_flat = packFlat(vals);
        applyStimulus(0, 1'b0, -1, '0, lastCyc);
        checkOutput("full-rate last accept cycle", lastCyc, 9);

        $display("[TB] alternating ready stream");
        applyStimulus(1, 1'b0, -1, '0, lastCyc);
        checkOutput("stalled last accept cycle", lastCyc, 18);

        $display("[TB] saturation table");
        tab[0] = '{300, 127, 1'b1};
        tab[1] = '{-200, -128, 1'b1};
        tab[2] = '{-5, -5, 1'b0};
        tab[3] = '{127, 127, 1'b0};
        tab[4] = '{-128, -128, 1'b0};
        tab[5] = '{128, 127, 1'b1};
        tab[6] = '{-129, -128, 1'b1};
        tab[7] = '{32767, 127, 1'b1};
        tab[8] = '{-32768, -128, 1'b1};
        for (int k = 0; k < 9; k++) begin
            vals[k] = tab[k].acc;
            expData[k] = tab[k].expOut;
            expSat[k] = tab[k].expSat;
        end
        altFlat = packFlat(vals);
        bus.c_flat = altFlat;
        applyStimulus(0, 1'b0, -1, '0, lastCyc);
        checkOutput("no overrun before collision", int'(bus.overrun), 0);

        $display("[TB] second done edge mid-stream");
        for (int k = 0; k < 9; k++) begin
            vals[k] = k + 1;
            expData[k] = k + 1;
            expSat[k] = 1'b0;
        end
        bus.c_flat = packFlat(vals);
        applyStimulus(0, 1'b0, 3, altFlat, lastCyc);
        bus.done = 1'b0;
        checkOutput("overrun set", int'(bus.overrun), 1);
        @(negedge clk);
        checkOutput("overrun sticky", int'(bus.overrun), 1);
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.clr_overrun = 1'b0;
        checkOutput("overrun cleared", int'(bus.overrun), 0);

        $display("[TB] done edge on final handshake");
        bus.c_flat = packFlat(vals);
        applyStimulus(0, 1'b0, 8, altFlat, lastCyc);
        bus.done = 1'b0;
        checkOutput("final-beat edge overrun", int'(bus.overrun), 1);
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.clr_overrun = 1'b0;
        checkOutput("final-beat edge not captured", int'(bus.busy), 0);

        $display("[TB] done held high across completion");
        bus.c_flat = packFlat(vals);
        applyStimulus(0, 1'b1, -1, '0, lastCyc);
        repeat (3) begin
            @(negedge clk);
            checkOutput("held done no retrigger", int'(bus.out_valid), 0);
        end
        checkOutput("held done overrun", int'(bus.overrun), 0);
        bus.done = 1'b0;
        @(negedge clk);

        $display("[TB] reset mid-stream");
        bus.done = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 4'd4) seen = 1;
        end
        checkOutput("reached beat 4", seen, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset valid", int'(bus.out_valid), 0);
        checkOutput("async reset busy", int'(bus.busy), 0);
        checkOutput("async reset idx", int'(bus.out_idx), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("held done after reset no stream", int'(bus.out_valid), 0);
        end
        bus.done = 1'b0;
        @(negedge clk);
        applyStimulus(0, 1'b0, -1, '0, lastCyc);
        checkOutput("fresh stream last accept cycle", lastCyc, 9);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
